bus_sel_xbar_arb: RTL and testbench

//  Parametrised successor to the fixed 4x4 fd->fifo bus-select transpose.

---
 rtl/bus_sel_xbar_arb.sv | 123 ++++++++++++
 tb/tb_bus_sel_xbar_arb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bus_sel_xbar_arb.sv
// Request crossbar from N_SRC frame decoders to N_DST fifos: one registered
// round-robin arbiter per fifo with grant hold, hold timeout and ready gate.
module bus_sel_xbar_arb #(
    parameter int N_SRC    = 4,
    parameter int N_DST    = 4,
    parameter int HOLD_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC*N_DST-1:0] fd_bus_sel,
    input  logic [N_DST-1:0]       fifo_ready,
    output logic [N_DST*N_SRC-1:0] fifo_bus_sel,
    output logic [N_SRC*N_DST-1:0] fd_bus_ack,
    output logic [N_DST-1:0]       bus_busy,
    output logic [N_DST-1:0]       hold_timeout
);

    localparam int SW        = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int HOLD_LAST = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Requests and grants regrouped per destination: [d][s]
    logic [N_DST-1:0][N_SRC-1:0] req;
    logic [N_DST-1:0][N_SRC-1:0] gnt;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_DST; gi++) begin : g_map_d
            for (gj = 0; gj < N_SRC; gj++) begin : g_map_s
                assign req[gi][gj]                 = fd_bus_sel[gj*N_DST+gi];
                assign fifo_bus_sel[gi*N_SRC+gj]   = gnt[gi][gj];
                assign fd_bus_ack[gj*N_DST+gi]     = gnt[gi][gj];
            end
        end

        for (gi = 0; gi < N_DST; gi++) begin : g_arb
            state_t            state_q, state_d;
            logic [SW-1:0]     owner_q, owner_d;
            logic [SW-1:0]     ptr_q, ptr_d;
            logic [CNT_W-1:0]  cnt_q, cnt_d;
            logic [N_SRC-1:0]  blk_q, blk_d;
            logic              to_q, to_d;
            logic [N_SRC-1:0]  req_m;
            logic [SW-1:0]     win;
            logic [SW-1:0]     idx;
            logic              found;

            always_comb begin
                // A source that timed out stays masked until it drops its request
                req_m = req[gi] & ~blk_q;
                win   = '0;
                idx   = '0;
                found = 1'b0;
                for (int k = 0; k < N_SRC; k++) begin
                    idx = SW'((int'(ptr_q) + k) % N_SRC);
                    if (!found && req_m[idx]) begin
                        win   = idx;
                        found = 1'b1;
                    end
                end

                state_d = state_q;
                owner_d = owner_q;
                ptr_d   = ptr_q;
                cnt_d   = cnt_q;
                to_d    = 1'b0;
                blk_d   = blk_q & req[gi];

                case (state_q)
                    IDLE: begin
                        if (fifo_ready[gi] && found) begin
                            state_d = GRANT;
                            owner_d = win;
                            cnt_d   = '0;
                        end
                    end
                    GRANT: begin
                        if (!req[gi][owner_q] ||
                            (HOLD_MAX != 0 && cnt_q == CNT_W'(HOLD_LAST))) begin
                            state_d = IDLE;
                            ptr_d   = (owner_q == SW'(N_SRC - 1)) ? '0 : owner_q + SW'(1);
                            if (req[gi][owner_q]) begin
                                to_d           = 1'b1;
                                blk_d[owner_q] = 1'b1;
                            end
                        end else if (cnt_q != CNT_W'(HOLD_MAX)) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= IDLE;
                    owner_q <= '0;
                    ptr_q   <= '0;
                    cnt_q   <= '0;
                    blk_q   <= '0;
                    to_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    owner_q <= owner_d;
                    ptr_q   <= ptr_d;
                    cnt_q   <= cnt_d;
                    blk_q   <= blk_d;
                    to_q    <= to_d;
                end
            end

            assign gnt[gi]          = (state_q == GRANT) ? (N_SRC'(1) << owner_q) : '0;
            assign bus_busy[gi]     = (state_q == GRANT);
            assign hold_timeout[gi] = to_q;
        end
    endgenerate

endmodule

// File: tb/tb_bus_sel_xbar_arb.sv
// Directed, table-driven bench for bus_sel_xbar_arb (4x4, HOLD_MAX=8) plus a
// hand-written timeout sequence.
module tb_bus_sel_xbar_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fd_bus_sel;
    logic [3:0]  fifo_ready;
    logic [15:0] fifo_bus_sel;
    logic [15:0] fd_bus_ack;
    logic [3:0]  bus_busy;
    logic [3:0]  hold_timeout;

    always #5 clk = ~clk;

    bus_sel_xbar_arb #(
        .N_SRC   (4),
        .N_DST   (4),
        .HOLD_MAX(8),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fd_bus_sel  (fd_bus_sel),
        .fifo_ready  (fifo_ready),
        .fifo_bus_sel(fifo_bus_sel),
        .fd_bus_ack  (fd_bus_ack),
        .bus_busy    (bus_busy),
        .hold_timeout(hold_timeout)
    );

    typedef struct {
        logic        rst_n;
        logic [15:0] req;
        logic [3:0]  rdy;
        logic [15:0] sel;
        logic [3:0]  busy;
        logic [3:0]  to;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [15:0] q, input logic [3:0] rd,
                       input logic [15:0] s, input logic [3:0] b, input logic [3:0] t,
                       input int n);
        vec_t v;
        v.rst_n = r; v.req = q; v.rdy = rd; v.sel = s; v.busy = b; v.to = t;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    // Grant layout (bit d*4+s) to request layout (bit s*4+d)
    function automatic logic [15:0] tr(input logic [15:0] g);
        logic [15:0] a;
        a = '0;
        for (int d = 0; d < 4; d++)
            for (int s = 0; s < 4; s++)
                a[s*4+d] = g[d*4+s];
        return a;
    endfunction

    task automatic rst_vec();
        add(1'b0, 16'h0000, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
    endtask

    initial begin
        int cycles;
        int got;

        rst_n      = 1'b0;
        fd_bus_sel = '0;
        fifo_ready = 4'hF;
        @(negedge clk);

        // Reset with every request high, then first grant
        add(1'b0, 16'hFFFF, 4'hF, 16'h0000, 4'h0, 4'h0, 2);
        add(1'b1, 16'hFFFF, 4'hF, 16'h1111, 4'hF, 4'h0, 1);
        add(1'b1, 16'h0000, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        // Single: fd2 -> fifo1
        rst_vec();
        add(1'b1, 16'h0200, 4'hF, 16'h0040, 4'h2, 4'h0, 2);
        add(1'b1, 16'h0000, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        // Round robin on fifo0: fd0, fd1, fd3, fd0
        rst_vec();
        add(1'b1, 16'h1011, 4'hF, 16'h0001, 4'h1, 4'h0, 3);
        add(1'b1, 16'h1010, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        add(1'b1, 16'h1010, 4'hF, 16'h0002, 4'h1, 4'h0, 3);
        add(1'b1, 16'h1001, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        add(1'b1, 16'h1001, 4'hF, 16'h0008, 4'h1, 4'h0, 3);
        add(1'b1, 16'h0001, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        add(1'b1, 16'h0001, 4'hF, 16'h0001, 4'h1, 4'h0, 1);
        add(1'b1, 16'h0000, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        // Timeout on fifo2: fd1 holds, fd3 waits
        rst_vec();
        add(1'b1, 16'h4040, 4'hF, 16'h0200, 4'h4, 4'h0, 8);
        add(1'b1, 16'h4040, 4'hF, 16'h0000, 4'h0, 4'h4, 1);
        add(1'b1, 16'h4040, 4'hF, 16'h0800, 4'h4, 4'h0, 1);
        add(1'b1, 16'h0040, 4'hF, 16'h0000, 4'h0, 4'h0, 4);
        add(1'b1, 16'h0000, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        add(1'b1, 16'h0040, 4'hF, 16'h0200, 4'h4, 4'h0, 1);
        add(1'b1, 16'h0000, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        // Ready gate on fifo3
        rst_vec();
        add(1'b1, 16'h0008, 4'h7, 16'h0000, 4'h0, 4'h0, 2);
        add(1'b1, 16'h0008, 4'hF, 16'h1000, 4'h8, 4'h0, 1);
        add(1'b1, 16'h0008, 4'h7, 16'h1000, 4'h8, 4'h0, 1);
        add(1'b1, 16'h0000, 4'h7, 16'h0000, 4'h0, 4'h0, 1);
        // Multicast and reset mid-grant
        rst_vec();
        add(1'b1, 16'h000F, 4'hF, 16'h1111, 4'hF, 4'h0, 2);
        add(1'b0, 16'h000F, 4'hF, 16'h0000, 4'h0, 4'h0, 1);
        add(1'b1, 16'h0000, 4'hF, 16'h0000, 4'h0, 4'h0, 1);

        foreach (vq[i]) begin
            rst_n      = vq[i].rst_n;
            fd_bus_sel = vq[i].req;
            fifo_ready = vq[i].rdy;
            @(negedge clk);
            chk("fifo_bus_sel", i, fifo_bus_sel, vq[i].sel);
            chk("fd_bus_ack", i, fd_bus_ack, tr(vq[i].sel));
            chk("bus_busy", i, {12'h000, bus_busy}, {12'h000, vq[i].busy});
            chk("hold_timeout", i, {12'h000, hold_timeout}, {12'h000, vq[i].to});
            $display("vec %0d rst_n=%b req=%h rdy=%b sel=%h ack=%h busy=%b to=%b",
                     i, rst_n, fd_bus_sel, fifo_ready, fifo_bus_sel, fd_bus_ack,
                     bus_busy, hold_timeout);
        end

        // Hand sequence: measure grant length on fifo2 until forced release
        rst_n      = 1'b0;
        fd_bus_sel = '0;
        fifo_ready = 4'hF;
        @(negedge clk);
        rst_n      = 1'b1;
        fd_bus_sel = 16'h0040;
        cycles     = 0;
        got        = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            @(negedge clk);
            if (hold_timeout[2]) got = 1;
            else if (bus_busy[2]) cycles++;
        end
        chk("to_seen", 0, 16'(got), 16'd1);
        chk("hold_len", 0, 16'(cycles), 16'd8);
        $display("seq timeout seen=%0d grant_cycles=%0d", got, cycles);

        fd_bus_sel = 16'h0044;
        @(negedge clk);
        chk("regrant_fd0", 0, fifo_bus_sel, 16'h0100);
        chk("to_pulse_len", 0, {12'h000, hold_timeout}, 16'h0000);
        $display("seq regrant sel=%h to=%b", fifo_bus_sel, hold_timeout);

        fd_bus_sel = 16'h0040;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fd1_blocked", i, {15'h0000, bus_busy[2]}, 16'h0000);
            $display("seq blocked %0d busy=%b", i, bus_busy);
        end

        fd_bus_sel = 16'h0000;
        @(negedge clk);
        fd_bus_sel = 16'h0040;
        @(negedge clk);
        chk("fd1_reraise", 0, fifo_bus_sel, 16'h0200);
        $display("seq reraise sel=%h", fifo_bus_sel);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
